// File: rtl/apb_seg_charlcd_ctrl_pkg.sv
// Shared definitions for the APB character-LCD / 7-segment / LED peripheral:
// register offsets, LCD engine state encoding, the LCD power-on init
// sequence and the hex-to-7-segment glyph decoder.
package apb_seg_charlcd_ctrl_pkg;

  // Register offsets as decoded from PADDR[3:2]
  localparam logic [1:0] REG_LCD_CMD = 2'd0;
  localparam logic [1:0] REG_LCD_DAT = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_SEG_LED = 2'd3;

  // SEG_LED bits [23:20] are not stored and always read back as zero
  localparam logic [31:0] SEG_LED_MASK = 32'hFF0F_FFFF;

  // LCD write engine states
  typedef logic [2:0] lcd_state_t;
  localparam lcd_state_t ST_PWRUP = 3'd0;
  localparam lcd_state_t ST_IDLE  = 3'd1;
  localparam lcd_state_t ST_SETUP = 3'd2;
  localparam lcd_state_t ST_ENH   = 3'd3;
  localparam lcd_state_t ST_HOLD  = 3'd4;
  localparam lcd_state_t ST_EXEC  = 3'd5;

  // Init sequence: 8-bit bus / 2 lines, display on, entry mode, clear
  localparam int INIT_LEN = 4;
  localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  // Hex digit to segments {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Clear-display and return-home commands need the long execution time
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02));
  endfunction

endpackage

// File: rtl/apb_seg_charlcd_ctrl_wr_engine.sv
// HD44780 write engine: waits out power-up, sends the init sequence, then
// transfers one latched byte at a time with setup / enable / hold phases
// followed by the controller's execution time. Every phase lasts exactly
// its parameter in cycles.
module charlcd_wr_engine
  import apb_seg_charlcd_ctrl_pkg::*;
#(
  parameter int T_SU        = 4,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 76000,
  parameter int T_PWRUP     = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [31:0] SU_M1    = 32'(T_SU - 1);
  localparam logic [31:0] EN_M1    = 32'(T_EN - 1);
  localparam logic [31:0] HOLD_M1  = 32'(T_HOLD - 1);
  localparam logic [31:0] EXEC_M1  = 32'(T_EXEC - 1);
  localparam logic [31:0] LONG_M1  = 32'(T_EXEC_LONG - 1);
  localparam logic [31:0] PWRUP_M1 = 32'(T_PWRUP - 1);
  localparam logic [1:0]  INIT_LAST = 2'(INIT_LEN - 1);

  lcd_state_t  state;
  logic [31:0] cnt;
  logic        pend_valid;
  logic        pend_rs;
  logic [7:0]  pend_data;
  logic [1:0]  init_idx;
  logic [1:0]  init_next;

  assign init_next = init_idx + 2'd1;

  // A pending byte counts as busy so a second write in that cycle overflows
  assign busy   = (state != ST_IDLE) || pend_valid;
  assign lcd_en = (state == ST_ENH);

  // Phase sequencing with a down-counter reloaded to (length-1) on entry;
  // init_idx stops at the last init entry, so later EXECs return to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_PWRUP;
      cnt        <= PWRUP_M1;
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= 8'h00;
      init_idx   <= 2'd0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      case (state)
        ST_PWRUP: begin
          if (cnt == 32'd0) begin
            state    <= ST_SETUP;
            cnt      <= SU_M1;
            lcd_rs   <= 1'b0;
            lcd_data <= INIT_SEQ[0];
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_IDLE: begin
          if (pend_valid) begin
            state      <= ST_SETUP;
            cnt        <= SU_M1;
            lcd_rs     <= pend_rs;
            lcd_data   <= pend_data;
            pend_valid <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt == 32'd0) begin
            state <= ST_ENH;
            cnt   <= EN_M1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_ENH: begin
          if (cnt == 32'd0) begin
            state <= ST_HOLD;
            cnt   <= HOLD_M1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 32'd0) begin
            state <= ST_EXEC;
            cnt   <= is_long_cmd(lcd_rs, lcd_data) ? LONG_M1 : EXEC_M1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ST_EXEC: begin
          if (cnt == 32'd0) begin
            if (init_idx != INIT_LAST) begin
              init_idx <= init_next;
              state    <= ST_SETUP;
              cnt      <= SU_M1;
              lcd_rs   <= 1'b0;
              lcd_data <= INIT_SEQ[init_next];
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 32'd0;
        end
      endcase
      if (wr_valid) begin
        pend_valid <= 1'b1;
        pend_rs    <= wr_rs;
        pend_data  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/apb_seg_charlcd_ctrl.sv
// APB3 peripheral: register decode, status / overflow flag, SEG_LED register,
// 4-digit multiplexed 7-segment scanner, LED drive, and the LCD write engine.
module apb_seg_charlcd_ctrl
  import apb_seg_charlcd_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int T_SU        = 4,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 76000,
  parameter int T_PWRUP     = 2_000_000,
  parameter int SCAN_DIV    = 50000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [11:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic [7:0]  LCD_DATA,
  output logic [7:0]  SEGOUT,
  output logic [3:0]  SEGCOM,
  output logic [7:0]  LED_OUT
);

  localparam logic [31:0] SCAN_M1 = 32'(SCAN_DIV - 1);

  logic [1:0]  reg_sel;
  logic        wr_commit;
  logic        lcd_wr;
  logic        busy;
  logic        ovf;
  logic [31:0] seg_led;
  logic [31:0] scan_cnt;
  logic [1:0]  scan_idx;
  logic [3:0]  nib;
  logic        dp;
  logic        unused_ok;

  assign unused_ok = ^{PADDR[11:4], PADDR[1:0], 32'(CLK_HZ)};

  assign reg_sel   = PADDR[3:2];
  assign wr_commit = PSEL && PENABLE && PWRITE;
  assign lcd_wr    = wr_commit && ((reg_sel == REG_LCD_CMD) || (reg_sel == REG_LCD_DAT));

  assign LCD_RW  = 1'b0;
  assign LED_OUT = seg_led[31:24];

  charlcd_wr_engine #(
    .T_SU        (T_SU),
    .T_EN        (T_EN),
    .T_HOLD      (T_HOLD),
    .T_EXEC      (T_EXEC),
    .T_EXEC_LONG (T_EXEC_LONG),
    .T_PWRUP     (T_PWRUP)
  ) u_engine (
    .clk      (PCLK),
    .rst      (PRESET),
    .wr_valid (lcd_wr && !busy),
    .wr_rs    (reg_sel == REG_LCD_DAT),
    .wr_data  (PWDATA[7:0]),
    .busy     (busy),
    .lcd_rs   (LCD_RS),
    .lcd_en   (LCD_EN),
    .lcd_data (LCD_DATA)
  );

  // Sticky overflow: a write dropped while busy sets it and beats a clear
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovf <= 1'b0;
    end else if (lcd_wr && busy) begin
      ovf <= 1'b1;
    end else if (wr_commit && (reg_sel == REG_STATUS) && PWDATA[1]) begin
      ovf <= 1'b0;
    end
  end

  // SEG_LED register; the unused nibble is never stored
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      seg_led <= 32'h0;
    end else if (wr_commit && (reg_sel == REG_SEG_LED)) begin
      seg_led <= PWDATA & SEG_LED_MASK;
    end
  end

  // Free-running digit scanner, independent of bus traffic
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      scan_cnt <= 32'd0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_M1) begin
      scan_cnt <= 32'd0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  // Select the active digit's nibble and decimal point
  always_comb begin
    nib = seg_led[3:0];
    dp  = seg_led[16];
    case (scan_idx)
      2'd1: begin nib = seg_led[7:4];   dp = seg_led[17]; end
      2'd2: begin nib = seg_led[11:8];  dp = seg_led[18]; end
      2'd3: begin nib = seg_led[15:12]; dp = seg_led[19]; end
      default: begin nib = seg_led[3:0]; dp = seg_led[16]; end
    endcase
  end

  assign SEGOUT = {dp, hex_to_seg(nib)};
  assign SEGCOM = ~(4'b0001 << scan_idx);

  // Zero-wait-state read mux; LCD registers are write-only
  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (reg_sel)
        REG_STATUS:  PRDATA = {30'b0, ovf, busy};
        REG_SEG_LED: PRDATA = seg_led;
        default:     PRDATA = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_seg_charlcd_ctrl.sv
// Directed self-checking bench for apb_seg_charlcd_ctrl with shortened timing
// parameters so power-up, long commands and scanning fit in a short run.
module tb_apb_seg_charlcd_ctrl;

  localparam int T_SU        = 4;
  localparam int T_EN        = 12;
  localparam int T_HOLD      = 4;
  localparam int T_EXEC      = 20;
  localparam int T_EXEC_LONG = 60;
  localparam int T_PWRUP     = 50;
  localparam int SCAN_DIV    = 10;

  logic        PCLK;
  logic        PRESET;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_EN;
  logic [7:0]  LCD_DATA;
  logic [7:0]  SEGOUT;
  logic [3:0]  SEGCOM;
  logic [7:0]  LED_OUT;

  int check_count = 0;
  int error_count = 0;
  int cycle_num   = 0;

  logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [3:0] com_table  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  apb_seg_charlcd_ctrl #(
    .CLK_HZ      (50_000_000),
    .T_SU        (T_SU),
    .T_EN        (T_EN),
    .T_HOLD      (T_HOLD),
    .T_EXEC      (T_EXEC),
    .T_EXEC_LONG (T_EXEC_LONG),
    .T_PWRUP     (T_PWRUP),
    .SCAN_DIV    (SCAN_DIV)
  ) u_dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_DATA (LCD_DATA),
    .SEGOUT   (SEGOUT),
    .SEGCOM   (SEGCOM),
    .LED_OUT  (LED_OUT)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cycle_num <= cycle_num + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // APB write; returns 1ns after the commit edge
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic readRegister(input logic [11:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    data = PRDATA;
  endtask

  task automatic checkResetOutputs(input string tag);
    PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 12'hC; #1;
    checkOutput({tag, " PRDATA unselected"}, PRDATA, 32'h0);
    checkOutput({tag, " LCD_EN"}, 32'(LCD_EN), 32'h0);
    checkOutput({tag, " LCD_RS"}, 32'(LCD_RS), 32'h0);
    checkOutput({tag, " LCD_DATA"}, 32'(LCD_DATA), 32'h0);
    checkOutput({tag, " LCD_RW"}, 32'(LCD_RW), 32'h0);
    checkOutput({tag, " SEGOUT"}, 32'(SEGOUT), 32'h3F);
    checkOutput({tag, " SEGCOM"}, 32'(SEGCOM), 32'hE);
    checkOutput({tag, " LED_OUT"}, 32'(LED_OUT), 32'h0);
    PSEL = 1'b1; PADDR = 12'h8; #1;
    checkOutput({tag, " STATUS"}, PRDATA, 32'h1);
    PADDR = 12'hC; #1;
    checkOutput({tag, " SEG_LED"}, PRDATA, 32'h0);
    PSEL = 1'b0;
  endtask

  // Called 1ns after the last reset edge; watches the power-up wait and init bytes
  task automatic runInit(input string tag);
    logic       prev_en;
    logic [7:0] got_data [4];
    logic       got_rs   [4];
    int         pulses;
    int         first_en;
    bit         done;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 12'h8;
    prev_en = 1'b0; pulses = 0; first_en = -1; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got_data[i] = 8'hxx;
      got_rs[i]   = 1'bx;
    end
    for (int j = 0; j < 3000 && !done; j++) begin
      @(negedge PCLK);
      if (LCD_EN && !prev_en) begin
        if (pulses == 0) first_en = j;
        if (pulses < 4) begin
          got_data[pulses] = LCD_DATA;
          got_rs[pulses]   = LCD_RS;
        end
        pulses++;
      end
      prev_en = LCD_EN;
      if (!PRDATA[0]) done = 1'b1;
    end
    checkOutput({tag, " first EN cycle"}, 32'(first_en), 32'(T_PWRUP + T_SU));
    checkOutput({tag, " EN pulse count"}, 32'(pulses), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, " init byte"}, 32'(got_data[i]), 32'(init_bytes[i]));
      checkOutput({tag, " init RS"}, 32'(got_rs[i]), 32'h0);
    end
    checkOutput({tag, " idle STATUS"}, PRDATA, 32'h0);
    PSEL = 1'b0;
  endtask

  // Sync to the start of digit 0 and check each slot's enable, glyph and length
  task automatic checkScan(input string tag, input logic [31:0] segs);
    logic [3:0] prev_com;
    bit         synced;
    PSEL = 1'b0;
    synced = 1'b0;
    @(negedge PCLK);
    prev_com = SEGCOM;
    for (int k = 0; k < 6 * SCAN_DIV && !synced; k++) begin
      @(negedge PCLK);
      if (SEGCOM == 4'b1110 && prev_com == 4'b0111) synced = 1'b1;
      else prev_com = SEGCOM;
    end
    checkOutput({tag, " scan sync"}, 32'(synced), 32'h1);
    for (int d = 0; d < 4; d++) begin
      checkOutput({tag, " SEGCOM slot start"}, 32'(SEGCOM), 32'(com_table[d]));
      checkOutput({tag, " SEGOUT"}, 32'(SEGOUT), 32'(segs[8*d +: 8]));
      repeat (SCAN_DIV - 1) @(negedge PCLK);
      checkOutput({tag, " SEGCOM slot end"}, 32'(SEGCOM), 32'(com_table[d]));
      @(negedge PCLK);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          busy_cnt;
    int          en_cnt;
    int          en_first;
    logic        rs_seen;
    logic [7:0]  data_seen;
    int          c0;
    int          c1;
    bit          bad_pulse;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 12'h0; PWDATA = 32'h0;
    repeat (3) @(posedge PCLK); #1;
    checkResetOutputs("reset");
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    runInit("init");

    // Data write while idle
    applyStimulus(12'h4, 32'h41);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 12'h8;
    busy_cnt = 0; en_cnt = 0; en_first = -1; rs_seen = 1'b0; data_seen = 8'h00;
    for (int k = 0; k < 100; k++) begin
      @(negedge PCLK);
      if (PRDATA[0]) busy_cnt++;
      if (LCD_EN) begin
        if (en_first < 0) begin
          en_first  = k;
          rs_seen   = LCD_RS;
          data_seen = LCD_DATA;
        end
        en_cnt++;
      end
    end
    checkOutput("dat busy cycles", 32'(busy_cnt), 32'(T_SU + T_EN + T_HOLD + T_EXEC + 1));
    checkOutput("dat EN high cycles", 32'(en_cnt), 32'(T_EN));
    checkOutput("dat write-to-EN", 32'(en_first), 32'(T_SU + 1));
    checkOutput("dat RS", 32'(rs_seen), 32'h1);
    checkOutput("dat DATA", 32'(data_seen), 32'h41);

    // Clear-display command with an overlapping dropped write
    applyStimulus(12'h0, 32'h01);
    c0 = cycle_num;
    applyStimulus(12'h4, 32'h55);
    readRegister(12'h8, rd);
    checkOutput("status busy+ovf", rd, 32'h3);
    c1 = 0; bad_pulse = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge PCLK);
      if (LCD_EN && LCD_DATA == 8'h55) bad_pulse = 1'b1;
      if (!PRDATA[0]) begin
        c1 = cycle_num;
        break;
      end
    end
    checkOutput("long cmd busy cycles", 32'(c1 - c0), 32'(T_SU + T_EN + T_HOLD + T_EXEC_LONG + 1));
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (LCD_EN) bad_pulse = 1'b1;
    end
    checkOutput("dropped write not sent", 32'(bad_pulse), 32'h0);
    readRegister(12'h8, rd);
    checkOutput("status ovf sticky", rd, 32'h2);
    applyStimulus(12'h8, 32'h2);
    readRegister(12'h8, rd);
    checkOutput("status ovf cleared", rd, 32'h0);

    // Segment / LED register
    applyStimulus(12'hC, 32'hA50F_1234);
    @(negedge PCLK);
    checkOutput("LED_OUT next cycle", 32'(LED_OUT), 32'hA5);
    readRegister(12'hC, rd);
    checkOutput("SEG_LED readback", rd, 32'hA50F_1234);
    checkScan("scan 1234 dp", 32'h86DB_CFE6);

    applyStimulus(12'hC, 32'h3CF0_FEDC);
    @(negedge PCLK);
    checkOutput("LED_OUT second", 32'(LED_OUT), 32'h3C);
    readRegister(12'hC, rd);
    checkOutput("SEG_LED masked readback", rd, 32'h3C00_FEDC);
    checkScan("scan FEDC", 32'h7179_5E39);

    // Reset in the middle of an enable pulse
    applyStimulus(12'h4, 32'h41);
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (LCD_EN) break;
    end
    checkOutput("EN high before reset", 32'(LCD_EN), 32'h1);
    PRESET = 1'b1;
    checkResetOutputs("mid-transfer reset");
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    runInit("re-init");

    // Read qualification
    applyStimulus(12'hC, 32'h1234_5678);
    readRegister(12'hC, rd);
    checkOutput("SEG_LED readback 3", rd, 32'h1204_5678);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PWRITE = 1'b0; PADDR = 12'hC;
    @(negedge PCLK);
    checkOutput("PRDATA with PSEL=0", PRDATA, 32'h0);
    readRegister(12'h0, rd);
    checkOutput("LCD_CMD reads 0", rd, 32'h0);
    readRegister(12'h4, rd);
    checkOutput("LCD_DAT reads 0", rd, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 12'hC;
    @(negedge PCLK);
    checkOutput("PRDATA during write", PRDATA, 32'h0);
    PSEL = 1'b0; PWRITE = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/apb_seg_charlcd_ctrl.md
# apb_seg_charlcd_ctrl

APB3-style peripheral driving an HD44780-compatible character LCD (8-bit bus, write-only), a 4-digit multiplexed 7-segment display and 8 discrete LEDs. It sits on the SoC peripheral bus. Software writes LCD commands and characters, segment values and LED patterns through memory-mapped registers. All display timing is derived from the single bus clock.

## Interface
- CLK_HZ, 50_000_000: PCLK frequency, informational only.
- T_SU, 4: cycles from RS/DATA valid to EN rise.
- T_EN, 12: cycles EN stays high.
- T_HOLD, 4: cycles RS/DATA held after EN fall.
- T_EXEC, 2000: busy cycles after a normal command or data write.
- T_EXEC_LONG, 76000: busy cycles after command 0x01 or 0x02.
- T_PWRUP, 2_000_000: cycles waited after reset before the init sequence.
- SCAN_DIV, 50000: cycles per 7-segment digit slot.
- PCLK in 1: sole clock, rising edge.
- PRESET in 1: reset, asynchronous and active-high.
- PADDR in 12: byte address; bits [3:2] decoded, rest ignored.
- PSEL, PENABLE, PWRITE in 1 each: APB control.
- PWDATA in 32: write data.
- PRDATA out 32: read data.
- LCD_RS, LCD_RW, LCD_EN out 1 each: LCD control; LCD_RW is constant 0.
- LCD_DATA out 8: LCD data bus.
- SEGOUT out 8: {dp,g,f,e,d,c,b,a}, active-high.
- SEGCOM out 4: digit enables, active-low one-hot.
- LED_OUT out 8: LED drive.

## Operation
- Register map, by PADDR[3:2]:
  - 0x0 LCD_CMD: write only. PWDATA[7:0] is sent with RS=0.
  - 0x4 LCD_DAT: write only. PWDATA[7:0] is sent with RS=1.
  - 0x8 STATUS: read returns {30'b0, OVF, BUSY}. Writing 1 to bit1 clears OVF.
  - 0xC SEG_LED:
    - [15:0] hold four hex nibbles; digit i uses nibbles [4i+3:4i].
    - [19:16] are per-digit decimal points.
    - [31:24] drive LED_OUT.
    - Readback returns the stored value with [23:20] read as 0.
- Reading LCD_CMD or LCD_DAT returns 0.
- APB: no wait states and no error response.
  - A write commits on a PCLK edge with PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR when PSEL & !PWRITE, else 0.
- LCD engine FSM states: PWRUP, IDLE, SETUP, ENH, HOLD, EXEC.
  - After reset: PWRUP for T_PWRUP cycles.
  - Then the init sequence 0x38, 0x0C, 0x06, 0x01 is sent automatically, each as a command with its own EXEC wait.
  - After the sequence: IDLE.
  - IDLE with pending byte: SETUP, which drives RS and DATA.
  - SETUP (T_SU cycles) → ENH with EN=1 (T_EN cycles) → HOLD with EN=0 (T_HOLD cycles) → EXEC.
  - EXEC lasts T_EXEC_LONG if the byte was a command equal to 0x01 or 0x02, else T_EXEC. EXEC → IDLE.
- BUSY = 1 in every state except IDLE, including PWRUP and the init sequence.
- A CMD/DAT write accepted while BUSY=0 is latched and taken on the next cycle.
- A CMD/DAT write while BUSY=1 is dropped and sets sticky OVF.
- 7-segment:
  - A free-running counter advances the digit index 0→1→2→3→0 every SCAN_DIV cycles.
  - SEGCOM[i]=0 only for the active digit.
  - SEGOUT is the hex-decode (0–F, standard glyphs) of that digit's nibble, with dp taken from the matching bit.

## Timing
- Reset values:
  - PRDATA 0
  - LCD_RS, LCD_EN, LCD_DATA 0
  - SEGOUT 0x3F (digit 0 shows '0')
  - SEGCOM 4'b1110
  - LED_OUT 0
  - SEG_LED register 0, OVF 0, BUSY 1
  - scan index 0
- Reset asserted mid-transfer forces EN=0 immediately and restarts PWRUP.
- Write-to-EN latency: EN rises T_SU+1 cycles after the write-commit edge.
- Total busy time for a normal byte is T_SU+T_EN+T_HOLD+T_EXEC+1 cycles.
- LED_OUT and the segment data update on the cycle after the write-commit edge. The scan phase is unaffected by writes.
- A STATUS write clearing OVF in the same cycle as an overflowing write leaves OVF=1; set wins.
- Counters saturate or reload exactly, with no off-by-one: each state lasts exactly its parameter in cycles.

## Structure
- Shared package:
  - register offset constants
  - LCD FSM state enum
  - init-sequence constant array
  - hex-to-7-segment decode function
- Sub-module charlcd_wr_engine holds the PWRUP/init/write/EXEC FSM and timers. The top holds APB decode, registers and the segment scanner.

## Test plan
- Reset, run T_PWRUP plus the init sequence. Required: EN pulses with DATA 0x38, 0x0C, 0x06, 0x01, all RS=0, then BUSY reads 0.
- Write LCD_DAT=0x41 when idle. Required: RS=1, DATA=0x41, EN high for exactly T_EN cycles, BUSY=1 for T_SU+T_EN+T_HOLD+T_EXEC+1 cycles.
- Write LCD_CMD=0x01. Required: EXEC lasts T_EXEC_LONG. A second LCD_DAT write during it is dropped, and STATUS reads 0x3. Writing STATUS=0x2 then reads 0x0.
- Write SEG_LED=0xA5_0F_1234. Required:
  - LED_OUT=0xA5 next cycle.
  - Readback 0xA50F1234 (bits [23:20] read 0).
  - Over 4·SCAN_DIV cycles: SEGCOM 1110/1101/1011/0111 with SEGOUT 0xE6/0xCF/0xDB/0x86 (digits 4,3,2,1 with dp set).
- Assert PRESET during ENH. Required: EN=0 immediately, all outputs return to their reset values, PWRUP restarts.
- Read with PSEL=0. Required: PRDATA=0.
